// File: rtl/x_ddr_pkg.sv
// Shared encodings for the DDR input capture path.
//   ALIGN_*   : pair-output alignment (NONE = native edges, C0 = both retimed to rise)
//   SRTYPE_*  : R/S behaviour on the capture registers (SYNC = on capture edge, ASYNC = immediate)
//   FIFO_DEPTH: word buffer depth behind the deserializer
package x_ddr_pkg;

  localparam logic ALIGN_NONE   = 1'b0;
  localparam logic ALIGN_C0     = 1'b1;

  localparam logic SRTYPE_SYNC  = 1'b0;
  localparam logic SRTYPE_ASYNC = 1'b1;

  localparam int   FIFO_DEPTH   = 2;

endpackage

// File: rtl/x_iddr2_capture.sv
// DDR capture stage: r0 samples d on rise of c, r1 samples d on the following fall.
// Applies INIT/R/S to the capture registers and produces the pair outputs in either
// native (NONE) or rise-retimed (C0) alignment.
// Ports:
//   c, rn        clock and async active-low reset
//   d, ce        pad data and capture enable
//   r, s         reset / set of the capture regs (r wins)
//   q0, q1       pair outputs in the selected alignment
//   pair0/pair1  raw capture regs, consumed by the deserializer at the next enabled rise
//   pair_vld     capture regs hold real data (set by an enabled rise, cleared by RN or R)
module x_iddr2_capture
  import x_ddr_pkg::*;
#(
  parameter string DDR_ALIGNMENT = "NONE",
  parameter logic  INIT          = 1'b0,
  parameter string SRTYPE        = "SYNC"
) (
  input  logic c,
  input  logic rn,
  input  logic d,
  input  logic ce,
  input  logic r,
  input  logic s,
  output logic q0,
  output logic q1,
  output logic pair0,
  output logic pair1,
  output logic pair_vld
);

  localparam logic ALIGN = (DDR_ALIGNMENT == "C0")  ? ALIGN_C0     : ALIGN_NONE;
  localparam logic SRT   = (SRTYPE == "ASYNC")      ? SRTYPE_ASYNC : SRTYPE_SYNC;

  logic r0_q, r0_d;
  logic r1_q, r1_d;
  logic vld_q, vld_d;

  always_comb begin
    r0_d = r0_q;
    if (r)       r0_d = 1'b0;
    else if (s)  r0_d = 1'b1;
    else if (ce) r0_d = d;

    r1_d = r1_q;
    if (r)       r1_d = 1'b0;
    else if (s)  r1_d = 1'b1;
    else if (ce) r1_d = d;

    // A pair captured under R is forced data, not pad data, so it is never consumed.
    vld_d = vld_q;
    if (r)       vld_d = 1'b0;
    else if (ce) vld_d = 1'b1;
  end

  // Each capture reg honours R/S on its own edge in SYNC mode.
  generate
    if (SRT == SRTYPE_ASYNC) begin : g_async
      always_ff @(posedge c or negedge rn or posedge r or posedge s) begin
        if (!rn)     r0_q <= INIT;
        else if (r)  r0_q <= 1'b0;
        else if (s)  r0_q <= 1'b1;
        else         r0_q <= r0_d;
      end
      always_ff @(negedge c or negedge rn or posedge r or posedge s) begin
        if (!rn)     r1_q <= INIT;
        else if (r)  r1_q <= 1'b0;
        else if (s)  r1_q <= 1'b1;
        else         r1_q <= r1_d;
      end
    end else begin : g_sync
      always_ff @(posedge c or negedge rn) begin
        if (!rn) r0_q <= INIT;
        else     r0_q <= r0_d;
      end
      always_ff @(negedge c or negedge rn) begin
        if (!rn) r1_q <= INIT;
        else     r1_q <= r1_d;
      end
    end
  endgenerate

  always_ff @(posedge c or negedge rn) begin
    if (!rn) vld_q <= 1'b0;
    else     vld_q <= vld_d;
  end

  generate
    if (ALIGN == ALIGN_C0) begin : g_c0
      logic a0_q, a0_d;
      logic a1_q, a1_d;

      always_comb begin
        a0_d = ce ? r0_q : a0_q;
        a1_d = ce ? r1_q : a1_q;
      end

      always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
          a0_q <= INIT;
          a1_q <= INIT;
        end else begin
          a0_q <= a0_d;
          a1_q <= a1_d;
        end
      end

      assign q0 = a0_q;
      assign q1 = a1_q;
    end else begin : g_none
      assign q0 = r0_q;
      assign q1 = r1_q;
    end
  endgenerate

  assign pair0    = r0_q;
  assign pair1    = r1_q;
  assign pair_vld = vld_q;

endmodule

// File: rtl/x_iddr2_deser.sv
// DDR input register with deserializer. Captures D on both edges of C, presents the
// pair on Q0/Q1 and packs the bit stream (Q0 bit first) into WIDTH-bit words held in a
// 2-entry valid/ready buffer whose head is the registered WORD/WORD_VALID.
// Ports:
//   C, RN                 clock and async active-low reset
//   D, CE, R, S           pad data, enable, capture reset/set (R also flushes the packer)
//   Q0, Q1                captured pair
//   BITSLIP               drop the Q0 bit of the pair consumed at this rise
//   WORD, WORD_VALID      buffer head
//   WORD_READY            consumer accept
//   OVERFLOW              sticky: a completed word found the buffer full
// Build option: define X_IDDR2_BITSLIP_EN to enable BITSLIP; otherwise it is ignored.
module x_iddr2_deser
  import x_ddr_pkg::*;
#(
  parameter string DDR_ALIGNMENT = "NONE",
  parameter logic  INIT          = 1'b0,
  parameter string SRTYPE        = "SYNC",
  parameter int    WIDTH         = 8
) (
  input  logic             C,
  input  logic             RN,
  input  logic             D,
  input  logic             CE,
  input  logic             R,
  input  logic             S,
  output logic             Q0,
  output logic             Q1,
  input  logic             BITSLIP,
  output logic [WIDTH-1:0] WORD,
  output logic             WORD_VALID,
  input  logic             WORD_READY,
  output logic             OVERFLOW
);

  localparam int CW = $clog2(WIDTH);

  logic pair0, pair1, pair_vld;
  logic slip;

  x_iddr2_capture #(
    .DDR_ALIGNMENT (DDR_ALIGNMENT),
    .INIT          (INIT),
    .SRTYPE        (SRTYPE)
  ) u_capture (
    .c        (C),
    .rn       (RN),
    .d        (D),
    .ce       (CE),
    .r        (R),
    .s        (S),
    .q0       (Q0),
    .q1       (Q1),
    .pair0    (pair0),
    .pair1    (pair1),
    .pair_vld (pair_vld)
  );

`ifdef X_IDDR2_BITSLIP_EN
  assign slip = BITSLIP;
`else
  logic unused_bitslip;
  assign unused_bitslip = BITSLIP;
  assign slip = 1'b0;
`endif

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             word_vld_q, word_vld_d;
  logic [WIDTH-1:0] f1_q, f1_d;
  logic             f1_vld_q, f1_vld_d;
  logic             ovf_q, ovf_d;

  logic             push, pop, full;
  logic [WIDTH-1:0] push_word;
  logic [1:0]       bits, bit_en;
  logic [1:0]       occ;

  // Packer: append up to two bits in stream order; a bit landing on the last slot
  // closes the word and any following bit starts the next word at bit 0.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_word = '0;
    bits      = slip ? {1'b0, pair1} : {pair1, pair0};
    bit_en    = slip ? 2'b01 : 2'b11;
    if (CE && pair_vld) begin
      for (int i = 0; i < 2; i++) begin
        if (bit_en[i]) begin
          acc_d[cnt_d] = bits[i];
          if (cnt_d == CW'(WIDTH - 1)) begin
            push      = 1'b1;
            push_word = acc_d;
            acc_d     = '0;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_d + 1'b1;
          end
        end
      end
    end
    if (R) begin
      acc_d = '0;
      cnt_d = '0;
      push  = 1'b0;
    end
  end

  // Two-entry buffer: head is the output register, f1 is the spill slot.
  always_comb begin
    occ        = {1'b0, word_vld_q} + {1'b0, f1_vld_q};
    full       = (occ == 2'(FIFO_DEPTH));
    pop        = word_vld_q && WORD_READY;
    word_d     = word_q;
    word_vld_d = word_vld_q;
    f1_d       = f1_q;
    f1_vld_d   = f1_vld_q;
    ovf_d      = ovf_q;
    if (pop) begin
      word_d     = f1_q;
      word_vld_d = f1_vld_q;
      f1_vld_d   = 1'b0;
    end
    if (push) begin
      if (full && !pop) begin
        ovf_d = 1'b1;
      end else if (!word_vld_d) begin
        word_d     = push_word;
        word_vld_d = 1'b1;
      end else begin
        f1_d     = push_word;
        f1_vld_d = 1'b1;
      end
    end
    if (R) ovf_d = 1'b0;
  end

  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
      f1_q       <= '0;
      f1_vld_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      word_vld_q <= word_vld_d;
      f1_q       <= f1_d;
      f1_vld_q   <= f1_vld_d;
      ovf_q      <= ovf_d;
    end
  end

  assign WORD       = word_q;
  assign WORD_VALID = word_vld_q;
  assign OVERFLOW   = ovf_q;

endmodule
